// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch port and a
// data port. Only one access is in flight, and ties alternate between the two ports.
module mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        if_done,
  output logic        dm_done,
  output logic [15:0] if_rdata,
  output logic [15:0] dm_rdata,
  output logic        if_stall,
  output logic        dm_stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  state_t        next_state;
  logic          owner;
  logic          last_owner;
  logic          grant_data;
  logic          timeout_hit;
  logic          start;
  logic          access_end;
  logic [15:0]   rdata_val;
  logic [CW-1:0] wait_cnt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; a tie goes to whichever port was not served last
  always_comb begin
    next_state  = state;
    grant_data  = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (if_req && dm_req) grant_data = ~last_owner;
        else                  grant_data = dm_req;
        if (if_req || dm_req) next_state = ISSUE;
      end
      ISSUE: next_state = WAIT;
      WAIT: begin
        if (mem_done) begin
          next_state = DONE;
        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          next_state  = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign start      = (state == IDLE) && (next_state == ISSUE);
  assign access_end = (state == WAIT) && (mem_done || timeout_hit);
  assign rdata_val  = mem_done ? mem_rdata : 16'h0000;

  // Memory command is captured at grant so it is already valid during ISSUE and held in WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= 16'h0000;
      mem_wdata  <= 16'h0000;
      owner      <= 1'b0;
      last_owner <= 1'b0;
      wait_cnt   <= '0;
      if_rdata   <= 16'h0000;
      dm_rdata   <= 16'h0000;
      err        <= 1'b0;
    end else begin
      mem_en <= start;
      if (start) begin
        owner     <= grant_data;
        mem_wr    <= grant_data & dm_wr;
        mem_addr  <= grant_data ? dm_addr : if_addr;
        mem_wdata <= grant_data ? dm_wdata : 16'h0000;
      end
      if (state == ISSUE)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + CW'(1);
      if (access_end) begin
        if (!owner)       if_rdata <= rdata_val;
        else if (!mem_wr) dm_rdata <= rdata_val;
      end
      if (timeout_hit) err <= 1'b1;
      if (state == DONE) last_owner <= owner;
    end
  end

  // Completion pulses and pipeline stalls
  always_comb begin
    if_done  = (state == DONE) && !owner;
    dm_done  = (state == DONE) && owner;
    if_stall = if_req && !if_done;
    dm_stall = dm_req && !dm_done;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, hand-written corner sequences and a randomized
// run checked against a transaction-level schedule model of the arbiter.
module tb_mem_arbiter;

  localparam int TIMEOUT = 4;

  logic        clk, rst;
  logic        if_req, dm_req, dm_wr;
  logic [15:0] if_addr, dm_addr, dm_wdata;
  logic        if_done, dm_done, if_stall, dm_stall;
  logic [15:0] if_rdata, dm_rdata;
  logic        mem_en, mem_wr, mem_done, err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Memory responder: resp_lat cycles after mem_en it pulses mem_done; 0 means never
  int          resp_lat = 1;
  logic [15:0] resp_data = 16'h0000;
  logic        stray = 1'b0;
  logic        pend = 1'b0;
  logic        pwr = 1'b0;
  int          pcnt = 0;
  logic [15:0] presp = 16'h0000;

  typedef struct {
    logic        is_data;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] mdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[12];

  // Transaction-level model state for the random run
  logic        busy, m_owner, m_last, m_wr, exp_done;
  logic [15:0] m_addr, m_wdata, m_rd, m_if, m_dm;
  int          grant_cyc, done_cyc, free_at, lat;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .if_done(if_done), .dm_done(dm_done),
    .if_rdata(if_rdata), .dm_rdata(dm_rdata),
    .if_stall(if_stall), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [15:0] ia, input logic dr,
                               input logic dw, input logic [15:0] da, input logic [15:0] dd);
    if_req   = ir;
    if_addr  = ia;
    dm_req   = dr;
    dm_wr    = dw;
    dm_addr  = da;
    dm_wdata = dd;
  endtask

  // Advance to the next falling edge, then update the memory responder for that cycle
  task automatic tick();
    @(negedge clk);
    cyc++;
    mem_done = 1'b0;
    if (stray) begin
      mem_done  = 1'b1;
      mem_rdata = 16'hFFFF;
      stray     = 1'b0;
    end
    if (pend) begin
      if (pcnt == 1) begin
        mem_done  = 1'b1;
        mem_rdata = pwr ? 16'hDEAD : presp;
        pend      = 1'b0;
      end else begin
        pcnt--;
      end
    end
    if (mem_en && resp_lat != 0) begin
      pend  = 1'b1;
      pcnt  = resp_lat;
      pwr   = mem_wr;
      presp = resp_data;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    pend  = 1'b0;
    stray = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mem_en"},    32'(mem_en),    32'd0);
    checkOutput({tag, "_mem_wr"},    32'(mem_wr),    32'd0);
    checkOutput({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    checkOutput({tag, "_if_done"},   32'(if_done),   32'd0);
    checkOutput({tag, "_dm_done"},   32'(dm_done),   32'd0);
    checkOutput({tag, "_if_rdata"},  32'(if_rdata),  32'd0);
    checkOutput({tag, "_dm_rdata"},  32'(dm_rdata),  32'd0);
    checkOutput({tag, "_err"},       32'(err),       32'd0);
    checkOutput({tag, "_stalls"},    32'({if_stall, dm_stall}), 32'd0);
  endtask

  // One isolated access issued from IDLE; done lands lat+2 cycles after the request cycle
  task automatic runVector(input vec_t v);
    int   done_k;
    logic ed;
    resp_lat  = v.lat;
    resp_data = v.mdata;
    if (v.is_data) applyStimulus(1'b0, 16'h0, 1'b1, v.wr, v.addr, v.wdata);
    else           applyStimulus(1'b1, v.addr, 1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    checkOutput("stall_at_req", 32'(v.is_data ? dm_stall : if_stall), 32'd1);
    done_k = (v.lat == 0) ? TIMEOUT + 2 : v.lat + 2;
    for (int k = 1; k <= done_k; k++) begin
      tick();
      ed = (k == done_k);
      checkOutput("mem_en",  32'(mem_en),  32'(k == 1));
      checkOutput("if_done", 32'(if_done), 32'(ed && !v.is_data));
      checkOutput("dm_done", 32'(dm_done), 32'(ed && v.is_data));
      checkOutput("stall",   32'(v.is_data ? dm_stall : if_stall), 32'(!ed));
      if (k < done_k) begin
        checkOutput("mem_addr",  32'(mem_addr),  32'(v.addr));
        checkOutput("mem_wr",    32'(mem_wr),    32'(v.is_data && v.wr));
        checkOutput("mem_wdata", 32'(mem_wdata), 32'(v.is_data ? v.wdata : 16'h0));
      end
    end
    checkOutput("rdata", 32'(v.is_data ? dm_rdata : if_rdata), 32'(v.exp_rdata));
    checkOutput("err",   32'(err), 32'(v.exp_err));
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    checkOutput("idle_mem_en", 32'(mem_en), 32'd0);
    checkOutput("idle_done",   32'({if_done, dm_done}), 32'd0);
  endtask

  initial begin
    int dcyc, fcyc, n, prev;
    logic seen_en;

    tbl[0]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1, 16'hBEEF, 16'hBEEF, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1, 16'h1357, 16'h1357, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 16'h0030, 16'h1234, 2, 16'h0000, 16'h1357, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 3, 16'h0000, 16'h0000, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 4, 16'hA5A5, 16'hA5A5, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 16'h8000, 16'h0000, 2, 16'h0F0F, 16'h0F0F, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 16'h0044, 16'h0000, 0, 16'h9999, 16'h0000, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 16'h0046, 16'h0000, 0, 16'h9999, 16'h0000, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 16'h0050, 16'h0000, 1, 16'h7777, 16'h7777, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 16'h0052, 16'h0000, 2, 16'h8888, 16'h8888, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 16'h0ABC, 16'h0000, 1, 16'h1111, 16'h1111, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 16'h0DEF, 16'h0000, 3, 16'h2222, 16'h2222, 1'b0};

    mem_done  = 1'b0;
    mem_rdata = 16'h0000;
    doReset();
    checkAllZero("reset");

    for (int i = 0; i < 10; i++) runVector(tbl[i]);

    // Reset while the access sits in WAIT: no done pulse, everything back to zero
    resp_lat  = 3;
    resp_data = 16'h5555;
    applyStimulus(1'b1, 16'h0ABC, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    tick();
    rst    = 1'b1;
    if_req = 1'b0;
    pend   = 1'b0;
    tick();
    checkAllZero("midrst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("midrst_no_done", 32'({if_done, dm_done, mem_en}), 32'd0);
    end
    runVector(tbl[10]);

    // Stray completion in IDLE must be ignored
    stray = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stray_quiet",    32'({if_done, dm_done, mem_en}), 32'd0);
      checkOutput("stray_if_rdata", 32'(if_rdata), 32'h1111);
      checkOutput("stray_err",      32'(err), 32'd0);
    end
    runVector(tbl[11]);

    // Tie after reset: data write first, fetch four cycles later
    doReset();
    resp_lat  = 1;
    resp_data = 16'h4444;
    applyStimulus(1'b1, 16'h0040, 1'b1, 1'b1, 16'h0020, 16'h1234);
    dcyc = -100;
    fcyc = 0;
    seen_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("tie_exclusive", 32'(if_done && dm_done), 32'd0);
      if (mem_en && !seen_en) begin
        seen_en = 1'b1;
        checkOutput("tie_first_wr",    32'(mem_wr),    32'd1);
        checkOutput("tie_first_addr",  32'(mem_addr),  32'h0020);
        checkOutput("tie_first_wdata", 32'(mem_wdata), 32'h1234);
      end
      if (dm_done) begin dcyc = cyc; dm_req = 1'b0; end
      if (if_done) begin
        fcyc = cyc;
        if_req = 1'b0;
        checkOutput("tie_if_rdata", 32'(if_rdata), 32'h4444);
        checkOutput("tie_dm_rdata", 32'(dm_rdata), 32'h0000);
      end
    end
    checkOutput("tie_spacing", 32'(fcyc - dcyc), 32'd4);

    // Sustained contention: grants alternate starting with data
    doReset();
    applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0, 16'h0200, 16'h0);
    n = 0;
    prev = 0;
    for (int i = 0; i < 60 && n < 6; i++) begin
      tick();
      if (if_done || dm_done) begin
        checkOutput("contention_order", 32'(dm_done), 32'((n % 2) == 0));
        if (n > 0) checkOutput("contention_gap", 32'(cyc - prev), 32'd4);
        prev = cyc;
        n++;
      end
    end
    checkOutput("contention_count", 32'(n), 32'd6);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Randomized run against the schedule model
    doReset();
    busy = 1'b0; m_last = 1'b0; m_owner = 1'b0; m_wr = 1'b0;
    m_if = 16'h0; m_dm = 16'h0; m_addr = 16'h0; m_wdata = 16'h0; m_rd = 16'h0;
    free_at = 0; grant_cyc = -10; done_cyc = -10;
    for (int i = 0; i < 600; i++) begin
      tick();
      exp_done = busy && (cyc == done_cyc);
      if (exp_done && !m_wr) begin
        if (m_owner) m_dm = m_rd;
        else         m_if = m_rd;
      end
      checkOutput("rnd_mem_en",   32'(mem_en),   32'(busy && cyc == grant_cyc + 1));
      checkOutput("rnd_if_done",  32'(if_done),  32'(exp_done && !m_owner));
      checkOutput("rnd_dm_done",  32'(dm_done),  32'(exp_done && m_owner));
      checkOutput("rnd_if_stall", 32'(if_stall), 32'(if_req && !(exp_done && !m_owner)));
      checkOutput("rnd_dm_stall", 32'(dm_stall), 32'(dm_req && !(exp_done && m_owner)));
      checkOutput("rnd_if_rdata", 32'(if_rdata), 32'(m_if));
      checkOutput("rnd_dm_rdata", 32'(dm_rdata), 32'(m_dm));
      checkOutput("rnd_err",      32'(err),      32'd0);
      if (busy && cyc > grant_cyc && cyc < done_cyc) begin
        checkOutput("rnd_mem_addr",  32'(mem_addr),  32'(m_addr));
        checkOutput("rnd_mem_wr",    32'(mem_wr),    32'(m_wr));
        checkOutput("rnd_mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      end
      if (exp_done) begin
        m_last = m_owner;
        busy   = 1'b0;
        if (m_owner) dm_req = 1'b0;
        else         if_req = 1'b0;
      end
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = 16'($urandom);
      end
      if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req   = 1'b1;
        dm_wr    = 1'($urandom);
        dm_addr  = 16'($urandom);
        dm_wdata = 16'($urandom);
      end
      if (!busy && cyc >= free_at && (if_req || dm_req)) begin
        m_owner   = (if_req && dm_req) ? !m_last : dm_req;
        busy      = 1'b1;
        lat       = int'($urandom_range(1, TIMEOUT));
        grant_cyc = cyc;
        done_cyc  = cyc + 2 + lat;
        free_at   = done_cyc + 1;
        m_wr      = m_owner && dm_wr;
        m_addr    = m_owner ? dm_addr : if_addr;
        m_wdata   = m_owner ? dm_wdata : 16'h0;
        m_rd      = 16'($urandom);
        resp_lat  = lat;
        resp_data = m_rd;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum cycles spent in WAIT before the access is aborted.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port if_req, input, 1, fetch read request; held high with stable if_addr until if_done.
REQ-005 SHALL have port if_addr, input, 16, fetch address.
REQ-006 SHALL have port dm_req, input, 1, data-stage request; held high with stable dm_wr/dm_addr/dm_wdata until dm_done.
REQ-007 SHALL have port dm_wr, input, 1, where 1 means write and 0 means read.
REQ-008 SHALL have ports dm_addr and dm_wdata, input, 16 each, data-stage address and write data.
REQ-009 SHALL have ports if_done and dm_done, output, 1 each, one-cycle completion pulses.
REQ-010 SHALL have ports if_rdata and dm_rdata, output, 16 each, registered read data, valid while the matching done is high.
REQ-011 SHALL have ports if_stall and dm_stall, output, 1 each, where stall = req AND NOT done, combinational, for pipeline hold.
REQ-012 SHALL have ports mem_en, mem_wr, mem_addr[16] and mem_wdata[16], output, registered command to the shared single-port memory.
REQ-013 SHALL have ports mem_rdata[16] and mem_done[1], input, memory read data and completion, sampled only in WAIT.
REQ-014 SHALL have port err, output, 1, sticky timeout flag.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT and DONE; the state register and owner bit (0 = fetch, 1 = data) are registered.
REQ-016 SHALL, in IDLE with exactly one request high, grant that requester, record the owner and go to ISSUE.
REQ-017 SHALL, in IDLE with both requests high, grant the requester not served most recently (last_owner); after reset, data wins the first tie.
REQ-018 SHALL, in ISSUE, drive mem_en=1 for exactly that one cycle, with mem_wr/mem_addr/mem_wdata from the owner (mem_wr=0 and mem_wdata=0 for fetch), then go to WAIT.
REQ-019 SHALL, in WAIT, keep mem_en=0 and hold mem_addr, mem_wr and mem_wdata stable.
REQ-020 SHALL, on mem_done=1 in WAIT, latch mem_rdata into the owner's rdata register (data writes leave dm_rdata unchanged) and go to DONE.
REQ-021 SHALL, in DONE, pulse the owner's done for exactly that one cycle, update last_owner, grant nothing, and go to IDLE.
REQ-022 SHALL have a minimum latency of req at cycle N, mem_en at N+1, mem_done at N+2 and done at N+3; back-to-back accesses are 4 cycles apart.
REQ-023 SHALL count WAIT cycles with a counter cleared on entry to WAIT; on reaching TIMEOUT without mem_done it sets err, latches rdata=16'h0000 for reads, and goes to DONE.
REQ-024 SHALL keep err sticky, cleared only by rst.
REQ-025 SHALL ignore mem_done outside WAIT.
REQ-026 SHALL never drive mem_en while in ISSUE, WAIT or DONE for a second request; a request arriving during an access waits for IDLE.
REQ-027 SHALL treat requests that drop before grant as withdrawn; a request dropped after grant has no effect on the FSM, and done still pulses.
REQ-028 SHALL never assert if_done and dm_done in the same cycle.

Reset
REQ-029 SHALL, on rst, force state IDLE and set mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0, if_done=0, dm_done=0, if_rdata=0, dm_rdata=0, err=0, counter=0 and last_owner=fetch.
REQ-030 SHALL, on rst mid-access, abandon the access with no done pulse; rst has priority over all transitions.

Verification
REQ-031 SHALL cover a single fetch: if_req=1, if_addr=0x0010, mem_done one cycle after mem_en, mem_rdata=0xBEEF -> mem_en at N+1, if_done at N+3, if_rdata=0xBEEF, if_stall high N..N+2.
REQ-032 SHALL cover a tie: if_req and dm_req (write 0x1234 to 0x0020) high in the same cycle -> data served first with mem_wr=1, then fetch; dm_done precedes if_done by 4 cycles.
REQ-033 SHALL cover sustained contention: both requests re-raised immediately for 6 accesses -> grants alternate data, fetch, data, fetch, data, fetch.
REQ-034 SHALL cover a timeout: mem_done never asserted with TIMEOUT=4 -> err=1 after 4 WAIT cycles, done pulse with rdata 0x0000, err stays 1 until rst.
REQ-035 SHALL cover reset mid-access: rst asserted in WAIT -> next cycle IDLE, no done pulse, all outputs 0; a subsequent fetch completes normally.
REQ-036 SHALL cover a stray completion: mem_done pulsed in IDLE -> no state change and no done output.
